// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Define PIPE_STAGE_STATS_EN to add the saturating o_stall_cnt output.
module pipe_stage_reg #(
  parameter int unsigned CTRL_SIZE = 20,
  parameter int unsigned DATA_SIZE = 256,
  parameter int unsigned SKID      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CTRL_SIZE-1:0] i_ctrl,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CTRL_SIZE-1:0] o_ctrl,
`ifdef PIPE_STAGE_STATS_EN
  output logic [15:0]          o_stall_cnt,
`endif
  output logic [DATA_SIZE-1:0] o_data
);

  logic                 r_h_v, r_s_v;
  logic [CTRL_SIZE-1:0] r_h_ctrl, r_s_ctrl;
  logic [DATA_SIZE-1:0] r_h_data, r_s_data;

  logic                 w_h_v_nxt, w_s_v_nxt;
  logic [CTRL_SIZE-1:0] w_h_ctrl_nxt, w_s_ctrl_nxt;
  logic [DATA_SIZE-1:0] w_h_data_nxt, w_s_data_nxt;

  logic w_accept, w_release, w_flush;

  // With a skid entry, o_ready depends only on a register, cutting the i_ready path.
  assign o_ready   = (SKID != 0) ? (i_enable & ~r_s_v) : (i_enable & (~r_h_v | i_ready));
  assign w_accept  = i_valid & o_ready & i_enable;
  assign w_release = r_h_v & i_ready & i_enable;
  assign w_flush   = i_flush & i_enable;

  assign o_valid = r_h_v;
  assign o_ctrl  = r_h_ctrl & {CTRL_SIZE{r_h_v}};
  assign o_data  = r_h_data;

  always_comb begin
    w_h_v_nxt    = r_h_v;
    w_h_ctrl_nxt = r_h_ctrl;
    w_h_data_nxt = r_h_data;
    w_s_v_nxt    = r_s_v;
    w_s_ctrl_nxt = r_s_ctrl;
    w_s_data_nxt = r_s_data;
    if (w_flush) begin
      w_h_v_nxt    = 1'b0;
      w_h_ctrl_nxt = '0;
      w_s_v_nxt    = 1'b0;
      w_s_ctrl_nxt = '0;
    end else if ((SKID != 0) && w_release && r_s_v) begin
      // o_ready is low while S is full, so no accept can collide with this move.
      w_h_v_nxt    = 1'b1;
      w_h_ctrl_nxt = r_s_ctrl;
      w_h_data_nxt = r_s_data;
      w_s_v_nxt    = 1'b0;
      w_s_ctrl_nxt = '0;
    end else if (w_accept) begin
      if ((SKID == 0) || !r_h_v || w_release) begin
        w_h_v_nxt    = 1'b1;
        w_h_ctrl_nxt = i_ctrl;
        w_h_data_nxt = i_data;
      end else begin
        w_s_v_nxt    = 1'b1;
        w_s_ctrl_nxt = i_ctrl;
        w_s_data_nxt = i_data;
      end
    end else if (w_release) begin
      w_h_v_nxt    = 1'b0;
      w_h_ctrl_nxt = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h_v    <= 1'b0;
      r_h_ctrl <= '0;
      r_h_data <= '0;
      r_s_v    <= 1'b0;
      r_s_ctrl <= '0;
      r_s_data <= '0;
    end else begin
      r_h_v    <= w_h_v_nxt;
      r_h_ctrl <= w_h_ctrl_nxt;
      r_h_data <= w_h_data_nxt;
      r_s_v    <= w_s_v_nxt;
      r_s_ctrl <= w_s_ctrl_nxt;
      r_s_data <= w_s_data_nxt;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (r_h_v && !i_ready && i_enable && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
